// File: rtl/reg_file_sb_pkg.sv
// ============================================================================
// Module  : reg_file_sb_pkg
// Purpose : Shared constants and helpers for the scoreboarded register file.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_sb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_NUM_RD = 2;

  // Register 0 is hardwired to zero and never marked pending.
  localparam int ZERO_REG = 0;

  // Upper bounds for the generic index-slice helper.
  localparam int IDX_MAX_W   = 16;
  localparam int IDX_BUS_MAX = 256;

  // Extracts port p's index from a packed index bus of aw-bit fields.
  function automatic logic [IDX_MAX_W-1:0] port_index(
    input logic [IDX_BUS_MAX-1:0] bus,
    input int unsigned            p,
    input int unsigned            aw
  );
    logic [IDX_BUS_MAX-1:0] shifted;
    logic [IDX_MAX_W-1:0]   mask;
    shifted = bus >> (p * aw);
    mask    = IDX_MAX_W'((64'd1 << aw) - 64'd1);
    return shifted[IDX_MAX_W-1:0] & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_sb_popcnt.sv
// ============================================================================
// Module  : reg_file_sb_popcnt
// Purpose : Combinational population count of the pending-write vector.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sb_popcnt #(
  parameter int N = 16,
  parameter int W = 5
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] count
);

  // Sum every set bit of the vector.
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(vec[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
// ============================================================================
// Module  : reg_file_sb
// Purpose : Parametrised register file (reg 0 = zero) with combinational read
//           ports and a per-register pending-write scoreboard for RAW hazard
//           detection between issue and write-back.
// Options : REG_FILE_SB_BYPASS_EN - forward same-cycle write-back data to the
//           read ports and clear their busy flag.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_reg_index,
  output logic [NUM_RD*DATA_W-1:0] reg_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_reg_index,
  input  logic [DATA_W-1:0]        wr_reg_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_reg_index,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]      r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]    r_pend;
  logic [ADDR_W:0]        r_pend_cnt;
  logic [NUM_REGS-1:0]    w_pend_nxt;
  logic [ADDR_W:0]        w_pend_cnt_nxt;
  logic                   w_wr_ok;
  logic                   w_iss_ok;
  logic [IDX_BUS_MAX-1:0] w_idx_bus;

  assign w_wr_ok   = wr_en  && (wr_reg_index  != C_ZERO_IDX);
  assign w_iss_ok  = iss_en && (iss_reg_index != C_ZERO_IDX);
  assign w_idx_bus = IDX_BUS_MAX'(rd_reg_index);
  assign pend_cnt  = r_pend_cnt;

  // Next scoreboard: write-back clears, issue sets; issue applied last so a
  // same-index issue (new producer) wins over the retiring write.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_ok) begin
      w_pend_nxt[wr_reg_index] = 1'b0;
    end
    if (w_iss_ok) begin
      w_pend_nxt[iss_reg_index] = 1'b1;
    end
  end

  reg_file_sb_popcnt #(
    .N (NUM_REGS),
    .W (ADDR_W + 1)
  ) u_popcnt (
    .vec   (w_pend_nxt),
    .count (w_pend_cnt_nxt)
  );

  // Register array, scoreboard and its count all update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (w_wr_ok) begin
        r_regs[wr_reg_index] <= wr_reg_data;
      end
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_pend_cnt_nxt;
    end
  end

  // One combinational read port per slice of the packed index bus.
  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] w_idx;
      logic [DATA_W-1:0] w_arr_data;

      assign w_idx      = ADDR_W'(port_index(w_idx_bus, p, ADDR_W));
      assign w_arr_data = (w_idx == C_ZERO_IDX) ? '0 : r_regs[w_idx];

`ifdef REG_FILE_SB_BYPASS_EN
      logic w_byp;
      assign w_byp = w_wr_ok && (wr_reg_index == w_idx);
      assign reg_data[p*DATA_W +: DATA_W] = w_byp ? wr_reg_data : w_arr_data;
      // A same-cycle issue to the bypassed index keeps the register busy.
      assign rd_busy[p] = w_byp ? (w_iss_ok && (iss_reg_index == w_idx))
                                : r_pend[w_idx];
`else
      assign reg_data[p*DATA_W +: DATA_W] = w_arr_data;
      assign rd_busy[p]                   = r_pend[w_idx];
`endif
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
// ============================================================================
// Module  : tb_reg_file_sb
// Purpose : Directed self-checking bench for reg_file_sb (default parameters).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NUM_RD = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_RD*ADDR_W-1:0] rd_reg_index;
  logic [NUM_RD*DATA_W-1:0] reg_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_reg_index;
  logic [DATA_W-1:0]        wr_reg_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_reg_index;
  logic [ADDR_W:0]          pend_cnt;

  int n_vec;
  int n_err;

  reg_file_sb #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_reg_index  (rd_reg_index),
    .reg_data      (reg_data),
    .rd_busy       (rd_busy),
    .wr_en         (wr_en),
    .wr_reg_index  (wr_reg_index),
    .wr_reg_data   (wr_reg_data),
    .iss_en        (iss_en),
    .iss_reg_index (iss_reg_index),
    .pend_cnt      (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en         = 1'b0;
    wr_reg_index  = '0;
    wr_reg_data   = '0;
    iss_en        = 1'b0;
    iss_reg_index = '0;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] p0, input logic [ADDR_W-1:0] p1);
    rd_reg_index = {p1, p0};
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_reg_index = idx; wr_reg_data = d;
    tick();
    idle();
  endtask

  task automatic do_issue(input logic [ADDR_W-1:0] idx);
    iss_en = 1'b1; iss_reg_index = idx;
    tick();
    idle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    rd_reg_index = '0;
    idle();
    tick();
    rst = 1'b0;

    // Reset after some activity
    do_write(4'd10, 32'h0000_AAAA);
    do_write(4'd15, 32'h0000_BBBB);
    do_issue(4'd10);
    set_rd(4'd10, 4'd15);
    check("pre_rst_p0", 64'(reg_data[31:0]), 64'h0000_AAAA);
    check("pre_rst_cnt", 64'(pend_cnt), 64'd1);
    rst = 1'b1;
    wr_en = 1'b1; wr_reg_index = 4'd10; wr_reg_data = 32'h1111;
    iss_en = 1'b1; iss_reg_index = 4'd15;
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("rst_p0", 64'(reg_data[31:0]), 64'd0);
    check("rst_p1", 64'(reg_data[63:32]), 64'd0);
    check("rst_busy", 64'(rd_busy), 64'd0);
    check("rst_cnt", 64'(pend_cnt), 64'd0);

    // Write / read back on both ports
    do_write(4'd5, 32'd1234);
    set_rd(4'd5, 4'd5);
    check("wr5_p0", 64'(reg_data[31:0]), 64'd1234);
    check("wr5_p1", 64'(reg_data[63:32]), 64'd1234);

    // Register 0 ignores write and issue
    wr_en = 1'b1; wr_reg_index = 4'd0; wr_reg_data = 32'd2431;
    iss_en = 1'b1; iss_reg_index = 4'd0;
    tick();
    idle();
    set_rd(4'd0, 4'd5);
    check("r0_data", 64'(reg_data[31:0]), 64'd0);
    check("r0_busy", 64'(rd_busy[0]), 64'd0);
    check("r0_cnt", 64'(pend_cnt), 64'd0);

    // Scoreboard issue / write-back
    do_issue(4'd3);
    do_issue(4'd7);
    set_rd(4'd3, 4'd7);
    check("sb_cnt2", 64'(pend_cnt), 64'd2);
    check("sb_busy11", 64'(rd_busy), 64'b11);
    do_write(4'd3, 32'h0000_DEAD);
    #1;
    check("sb_cnt1", 64'(pend_cnt), 64'd1);
    check("sb_p0_data", 64'(reg_data[31:0]), 64'h0000_DEAD);
    check("sb_busy10", 64'(rd_busy), 64'b10);

    // Simultaneous write and issue, same index
    wr_en = 1'b1; wr_reg_index = 4'd9; wr_reg_data = 32'd55;
    iss_en = 1'b1; iss_reg_index = 4'd9;
    tick();
    idle();
    set_rd(4'd9, 4'd0);
    check("sim_data", 64'(reg_data[31:0]), 64'd55);
    check("sim_busy", 64'(rd_busy[0]), 64'd1);
    check("sim_cnt", 64'(pend_cnt), 64'd2);

    // Simultaneous write and issue, different indices (7 clears, 11 sets)
    wr_en = 1'b1; wr_reg_index = 4'd7; wr_reg_data = 32'h77;
    iss_en = 1'b1; iss_reg_index = 4'd11;
    tick();
    idle();
    set_rd(4'd7, 4'd11);
    check("diff_data7", 64'(reg_data[31:0]), 64'h77);
    check("diff_busy", 64'(rd_busy), 64'b10);
    check("diff_cnt", 64'(pend_cnt), 64'd2);

    // Bypass behaviour on a pending register holding 0
    do_issue(4'd4);
    set_rd(4'd0, 4'd4);
    check("byp_pre_cnt", 64'(pend_cnt), 64'd3);
    wr_en = 1'b1; wr_reg_index = 4'd4; wr_reg_data = 32'd77;
    #1;
`ifdef REG_FILE_SB_BYPASS_EN
    check("byp_same_data", 64'(reg_data[63:32]), 64'd77);
    check("byp_same_busy", 64'(rd_busy[1]), 64'd0);
`else
    check("byp_same_data", 64'(reg_data[63:32]), 64'd0);
    check("byp_same_busy", 64'(rd_busy[1]), 64'd1);
`endif
    tick();
    idle();
    #1;
    check("byp_post_data", 64'(reg_data[63:32]), 64'd77);
    check("byp_post_busy", 64'(rd_busy[1]), 64'd0);
    check("byp_post_cnt", 64'(pend_cnt), 64'd2);

    // Reset mid-operation drops pending bits; later write-back is ordinary
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_rd(4'd9, 4'd11);
    check("mid_rst_cnt", 64'(pend_cnt), 64'd0);
    check("mid_rst_busy", 64'(rd_busy), 64'b00);
    do_write(4'd9, 32'h1234_5678);
    #1;
    check("post_rst_wr", 64'(reg_data[31:0]), 64'h1234_5678);
    check("post_rst_cnt", 64'(pend_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
